// File: rtl/data_mem_pkg.sv
// Shared constants for the MEM-stage data memory: MMIO register offsets
// (relative to MMIO_BASE) and TCON bit positions.
package data_mem_pkg;

    localparam logic [7:0] OFS_TH      = 8'h00;
    localparam logic [7:0] OFS_TL      = 8'h04;
    localparam logic [7:0] OFS_TCON    = 8'h08;
    localparam logic [7:0] OFS_LED     = 8'h0C;
    localparam logic [7:0] OFS_BCD     = 8'h10;
    localparam logic [7:0] OFS_SYSTICK = 8'h14;

    localparam int TCON_EN  = 0;
    localparam int TCON_IE  = 1;
    localparam int TCON_IRQ = 2;

endpackage

// File: rtl/data_mem_mmio_timer.sv
// Reload timer (TH/TL/TCON), free-running SYSTICK and registered timer irq.
// Only instantiated when DATA_MEM_TIMER_EN is defined.
module mmio_timer
    import data_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_th,
    input  logic        wr_tl,
    input  logic        wr_tcon,
    input  logic [31:0] wdata,
    output logic [31:0] th,
    output logic [31:0] tl,
    output logic [2:0]  tcon,
    output logic [31:0] systick,
    output logic        irq
);

    logic ovf;
    logic set_irq;

    assign ovf     = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);
    assign set_irq = ovf && tcon[TCON_IE];
    assign irq     = tcon[TCON_IRQ];

    always_ff @(posedge clk) begin
        if (!reset) begin
            th      <= '0;
            tl      <= '0;
            tcon    <= '0;
            systick <= '0;
        end else begin
            systick <= systick + 32'd1;
            // Reload reads th before this edge, so a same-edge TH write
            // only takes effect at the following overflow.
            if (wr_th) th <= wdata;
            if (wr_tl)                tl <= wdata;
            else if (ovf)             tl <= th;
            else if (tcon[TCON_EN])   tl <= tl + 32'd1;
            // A pending overflow always wins over a software clear of irq.
            if (wr_tcon)      tcon <= {wdata[TCON_IRQ] | set_irq, wdata[TCON_IE], wdata[TCON_EN]};
            else if (set_irq) tcon[TCON_IRQ] <= 1'b1;
        end
    end

endmodule

// File: rtl/data_mem_mmio.sv
// MEM-stage data memory: word RAM plus an MMIO window (LED, BCD, and when
// DATA_MEM_TIMER_EN is defined, TH/TL/TCON/SYSTICK timer with irq).
module data_mem_mmio
    import data_mem_pkg::*;
#(
    parameter int          RAM_DEPTH = 1024,
    parameter int          LED_WIDTH = 16,
    parameter int          BCD_WIDTH = 12,
    parameter logic [31:0] MMIO_BASE = 32'h4000_0000
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          Address,
    input  logic [31:0]          Write_data,
    output logic [31:0]          Read_data,
    input  logic                 MemRead,
    input  logic                 MemWrite,
    output logic [LED_WIDTH-1:0] led,
    output logic [BCD_WIDTH-1:0] BCD,
    output logic                 irq
);

    localparam int RAM_AW = $clog2(RAM_DEPTH);

    logic [31:0]        ram [RAM_DEPTH];
    logic               in_win;
    logic [7:0]         ofs;
    logic [RAM_AW-1:0]  ram_idx;
    logic [31:0]        th, tl, systick;
    logic [2:0]         tcon;
    logic               unused_addr;

    assign in_win      = (Address[31:8] == MMIO_BASE[31:8]);
    assign ofs         = {Address[7:2], 2'b00};
    assign ram_idx     = Address[RAM_AW+1:2];
    assign unused_addr = ^Address[1:0];

    // RAM is never reset; writes are still blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (reset && MemWrite && !in_win) ram[ram_idx] <= Write_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            led <= '0;
            BCD <= '0;
        end else if (MemWrite && in_win) begin
            if (ofs == OFS_LED) led <= Write_data[LED_WIDTH-1:0];
            if (ofs == OFS_BCD) BCD <= Write_data[BCD_WIDTH-1:0];
        end
    end

`ifdef DATA_MEM_TIMER_EN
    logic wr_win;
    assign wr_win = MemWrite && in_win;

    mmio_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .wr_th   (wr_win && (ofs == OFS_TH)),
        .wr_tl   (wr_win && (ofs == OFS_TL)),
        .wr_tcon (wr_win && (ofs == OFS_TCON)),
        .wdata   (Write_data),
        .th      (th),
        .tl      (tl),
        .tcon    (tcon),
        .systick (systick),
        .irq     (irq)
    );
`else
    assign th      = '0;
    assign tl      = '0;
    assign tcon    = '0;
    assign systick = '0;
    assign irq     = 1'b0;
`endif

    always_comb begin
        Read_data = '0;
        if (MemRead) begin
            if (!in_win) begin
                Read_data = ram[ram_idx];
            end else begin
                case (ofs)
                    OFS_TH:      Read_data = th;
                    OFS_TL:      Read_data = tl;
                    OFS_TCON:    Read_data = {29'd0, tcon};
                    OFS_LED:     Read_data = 32'(led);
                    OFS_BCD:     Read_data = 32'(BCD);
                    OFS_SYSTICK: Read_data = systick;
                    default:     Read_data = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Scoreboard bench for data_mem_mmio; timer checks follow DATA_MEM_TIMER_EN.
module tb_data_mem_mmio;

    localparam logic [31:0] T = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] Write_data = '0;
    logic [31:0] Read_data;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [15:0] led;
    logic [11:0] BCD;
    logic        irq;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [31:0] exp_tick = '0;
    logic [31:0] mdl [8];

    always #10 clk = ~clk;

    // Reference SYSTICK: cleared on a reset edge, +1 on every other edge.
    always @(posedge clk) exp_tick <= reset ? exp_tick + 32'd1 : 32'd0;

    data_mem_mmio #(
        .RAM_DEPTH(1024), .LED_WIDTH(16), .BCD_WIDTH(12), .MMIO_BASE(T)
    ) dut (
        .clk(clk), .reset(reset), .Address(Address), .Write_data(Write_data),
        .Read_data(Read_data), .MemRead(MemRead), .MemWrite(MemWrite),
        .led(led), .BCD(BCD), .irq(irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Load: push expectation on drive, pop and compare once the comb path settles.
    task automatic ld(input logic [31:0] a, input logic [31:0] e, input string t);
        Address = a;
        MemRead = 1'b1;
        exp_q.push_back(e);
        tag_q.push_back(t);
        #1;
        chk(tag_q.pop_front(), Read_data, exp_q.pop_front());
        MemRead = 1'b0;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        Address = a;
        Write_data = d;
        MemWrite = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        for (int i = 0; i < 7; i++) ld(T + 32'(i * 4), 32'd0, "rst_mmio");
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_led", 32'(led), 32'd0);
        Address = 32'h10;
        #1 chk("rd_idle", Read_data, 32'd0);
        reset = 1'b1;

        st(32'h10, 32'hDEAD_BEEF);
        ld(32'h10, 32'hDEAD_BEEF, "ram_rd");
        ld(32'h1010, 32'hDEAD_BEEF, "ram_wrap");
        Address = 32'h10;
        #1 chk("rd_noload", Read_data, 32'd0);

        for (int i = 0; i < 8; i++) begin
            mdl[i] = $urandom;
            st(32'(32'h100 + i * 40), mdl[i]);
        end
        for (int i = 0; i < 8; i++) ld(32'(32'h100 + i * 40), mdl[i], "ram_rand");

        st(T + 32'h0C, 32'h0001_ABCD);
        st(T + 32'h10, 32'hFFFF_F3A5);
        chk("led_pin", 32'(led), 32'h0000_ABCD);
        chk("bcd_pin", 32'(BCD), 32'h0000_03A5);
        ld(T + 32'h0C, 32'h0000_ABCD, "led_rd");
        ld(T + 32'h10, 32'h0000_03A5, "bcd_rd");

        st(32'h18, 32'h1234_5678);
        st(T + 32'h18, 32'hFFFF_FFFF);
        ld(T + 32'h18, 32'd0, "unmapped_rd");
        ld(T + 32'hFC, 32'd0, "unmapped_top");
        ld(32'h18, 32'h1234_5678, "unmapped_noram");

`ifdef DATA_MEM_TIMER_EN
        ld(T + 32'h14, exp_tick, "systick");
        st(T + 32'h14, 32'h0);
        ld(T + 32'h14, exp_tick, "systick_ro");

        st(T + 32'h00, 32'hFFFF_FFFC);
        st(T + 32'h04, 32'hFFFF_FFFC);
        st(T + 32'h08, 32'd3);
        ld(T + 32'h04, 32'hFFFF_FFFC, "tl_start");
        chk("irq_idle", 32'(irq), 32'd0);
        repeat (3) @(negedge clk);
        ld(T + 32'h04, 32'hFFFF_FFFF, "tl_max");
        chk("irq_pre", 32'(irq), 32'd0);
        @(negedge clk);
        ld(T + 32'h04, 32'hFFFF_FFFC, "tl_reload");
        ld(T + 32'h08, 32'd7, "tcon_set");
        chk("irq_set", 32'(irq), 32'd1);

        Address = T + 32'h08; Write_data = 32'd3; MemWrite = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0;
        chk("irq_clr", 32'(irq), 32'd0);
        repeat (2) @(negedge clk);
        ld(T + 32'h04, 32'hFFFF_FFFF, "tl_max2");
        chk("irq_pre2", 32'(irq), 32'd0);

        Address = T + 32'h08; Write_data = 32'd3; MemWrite = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0;
        ld(T + 32'h08, 32'd7, "tcon_race");
        ld(T + 32'h04, 32'hFFFF_FFFC, "tl_reload2");
        chk("irq_race", 32'(irq), 32'd1);

        repeat (3) @(negedge clk);
        Address = T + 32'h04; Write_data = 32'd5; MemWrite = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0;
        ld(T + 32'h04, 32'd5, "tl_wr_wins");
        @(negedge clk);
        ld(T + 32'h04, 32'd6, "tl_race");
`else
        ld(T + 32'h14, 32'd0, "systick_off");
        st(T + 32'h04, 32'd5);
        st(T + 32'h08, 32'd3);
        ld(T + 32'h04, 32'd0, "tl_off");
        ld(T + 32'h08, 32'd0, "tcon_off");
        repeat (4) @(negedge clk);
        chk("irq_off", 32'(irq), 32'd0);
`endif

        reset = 1'b0;
        @(negedge clk);
        ld(T + 32'h04, 32'd0, "rst2_tl");
        ld(T + 32'h08, 32'd0, "rst2_tcon");
        ld(T + 32'h0C, 32'd0, "rst2_led");
        chk("rst2_irq", 32'(irq), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_mmio.md
# data_mem_mmio

Parametrised data memory for the pipeline MEM stage, combining a word-addressed RAM with a memory-mapped peripheral window (LED register, BCD/seven-segment register, 32-bit reload timer, free-running system tick). It replaces the fixed-size LED/BCD data memory. It adds configurable depth and peripheral widths, timer interrupt generation and defined behaviour for unmapped and out-of-range accesses.

## Interface
- `RAM_DEPTH`, default 1024: RAM words; power of two; index width `RAM_AW = $clog2(RAM_DEPTH)`.
- `LED_WIDTH`, default 16: LED register width, ≤32.
- `BCD_WIDTH`, default 12: BCD register width, ≤32. Holds {AN[3:0], segments[7:0]}.
- `MMIO_BASE`, default 32'h4000_0000: base of the peripheral window. A word is in the window when `Address[31:8] == MMIO_BASE[31:8]`.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `Address`  in  32  byte address; bits [1:0] ignored.
- `Write_data`  in  32  store data.
- `Read_data`  out  32  load data.
- `MemRead`  in  1  load strobe.
- `MemWrite`  in  1  store strobe.
- `led`  out  LED_WIDTH  LED register.
- `BCD`  out  BCD_WIDTH  seven-segment register.
- `irq`  out  1  timer interrupt; equals TCON[2].

## Operation
MMIO map, offsets from `MMIO_BASE`:
- 0x00 TH: reload value, R/W.
- 0x04 TL: count, R/W.
- 0x08 TCON: R/W; bit0 enable, bit1 irq-enable, bit2 irq-status; other bits read 0.
- 0x0C led: R/W; zero-extended on read.
- 0x10 BCD: R/W; zero-extended on read.
- 0x14 SYSTICK: read-only; writes ignored.
- Other window offsets read 0; writes to them are ignored.

RAM access:
- RAM handles every non-window address.
- Index = `Address[RAM_AW+1:2]`. Upper bits are ignored, so addresses wrap modulo RAM_DEPTH.
- RAM is not cleared by reset; contents after reset are undefined.

Read path:
- `Read_data` is combinational.
- `MemRead`=0 gives 0.
- `MemRead`=1 gives the RAM word or the MMIO register value, whichever the address selects.

Write path:
- When `MemWrite`=1, the selected RAM word or register takes `Write_data` at the clock edge; registers take the low bits.

Timer:
- While TCON[0]=1, TL increments every cycle.
- When TL = 32'hFFFF_FFFF and TCON[0]=1, TL loads TH on the next edge instead of wrapping. If TCON[1]=1 on that edge, TCON[2] is set.
- TCON[2] is sticky. Software clears it by writing TCON with bit2=0.

SYSTICK: increments every cycle from reset and wraps modulo 2^32.

Simultaneous events:
- CPU write to TL and timer increment/reload on the same edge: the CPU write wins.
- CPU write to TCON and an overflow setting bit2 on the same edge: bit2 = 1, and bits 0 and 1 take the written value. The interrupt is never lost.
- Write to TH on an overflow edge: the reload uses the old TH; the new TH applies from the next overflow.

## Timing
- Reset (`reset`=0 at an edge): TH, TL, TCON, led, BCD, SYSTICK are all 0, so `irq`=0. Reset overrides any write on that edge.
- Load latency: 0 cycles (combinational).
- Store latency: 1 edge. A load in the cycle after a store returns the new value.
- `irq` is registered. It rises on the edge after TL reaches all-ones with TCON[1:0]=2'b11.
- Timer period from enable with TL=TH=X: 2^32−X cycles between overflows.
- Reset asserted mid-count: the timer stops and clears on that edge. No interrupt is generated on that edge.

## Configuration
Macro: `DATA_MEM_TIMER_EN`.
- Defined: TH, TL, TCON, SYSTICK and `irq` are implemented as described above.
- Undefined: offsets 0x00–0x08 and 0x14 behave as unmapped (read 0, writes ignored). `irq` is tied to 0. No timer logic is synthesised.

## Structure
Shared package `data_mem_pkg` holds:
- offset constants `OFS_TH`, `OFS_TL`, `OFS_TCON`, `OFS_LED`, `OFS_BCD`, `OFS_SYSTICK`;
- TCON bit indices `TCON_EN`, `TCON_IE`, `TCON_IRQ`.

One sub-module, `mmio_timer`, holds TH/TL/TCON/SYSTICK, the overflow logic and `irq`. Its write port is selected by the top-level address decode. It is instantiated only under `DATA_MEM_TIMER_EN`.

## Test plan
- Reset, then read each MMIO register with `MemRead`=1 → all 0; `irq`=0; `Read_data`=0 whenever `MemRead`=0.
- Store 32'hDEADBEEF to 0x0000_0010, then load 0x0000_0010 and 0x0000_1010 (RAM_DEPTH=1024) → both return DEADBEEF (wrap).
- Write led=32'h0001_ABCD and BCD=32'hFFFF_F3A5 → `led`=16'hABCD and `BCD`=12'h3A5; loads return 0000ABCD and 000003A5.
- TH=TL=32'hFFFF_FFFC, TCON=3 → overflow 4 cycles after enable: TL reloads FFFF_FFFC and `irq`=1. Write TCON=3 → `irq` clears; next overflow 4 cycles later.
- Write to TCON on the overflow edge → bit2 stays set. Write TL=5 on the overflow edge → TL reads 6 on the next cycle.
- Load 0x4000_0018 → 0. Store to 0x4000_0014 → SYSTICK unaffected. Build without `DATA_MEM_TIMER_EN` → 0x4000_0004 reads 0 and `irq` stays 0.
